// File: rtl/cnn_win_feeder_if.sv
// Handshake bundle between the UART receive side, the convolution core and
// the window feeder. The master drives the byte strobe, frame restart and
// core busy flag; the slave (the feeder) returns the window pixel stream.
interface cnn_win_feeder_if;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       frame_clr;
  logic       core_bsy;
  logic       pix_vld;
  logic       pix;
  logic       win_first;
  logic       win_last;
  logic       frame_done;
  logic       byte_ovf;

  modport master (
    output rx_rdy, rx_data, frame_clr, core_bsy,
    input  pix_vld, pix, win_first, win_last, frame_done, byte_ovf
  );

  modport slave (
    input  rx_rdy, rx_data, frame_clr, core_bsy,
    output pix_vld, pix, win_first, win_last, frame_done, byte_ovf
  );
endinterface

// File: rtl/cnn_win_feeder.sv
// cnn_win_feeder: unpacks received bytes bit-serially into a 1-bit image RAM
// and streams every KxK stride-1 window to the convolution core as soon as
// the window's bottom-right pixel has landed.
// Optional build macro CNN_WIN_MSB_FIRST_EN: unpack bit 7 first instead of bit 0.
//
// Unpacker states:
//   state  | meaning
//   U_IDLE | waiting for a byte strobe
//   U_UNPK | writing the latched byte, one bit per cycle
//
// Window states:
//   state  | meaning
//   W_IDLE | waiting for window pixels, a free core and an unfinished frame
//   W_RD   | issuing K*K row-major read addresses
//   W_ADV  | stepping the window position, flagging the final window
module cnn_win_feeder #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3,
  parameter int AW    = $clog2(IMG_W*IMG_H+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  cnn_win_feeder_if.slave   bus
);

  localparam int            NPIX_I   = IMG_W*IMG_H;
  localparam int            IW       = $clog2(NPIX_I);
  localparam logic [AW-1:0] NPIX     = AW'(NPIX_I);
  localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);
  localparam logic [AW-1:0] BR_OFF   = AW'((K-1)*IMG_W + K-1);
  localparam logic [AW-1:0] KM1      = AW'(K-1);
  localparam logic [AW-1:0] C_LAST   = AW'(IMG_W-K);
  localparam logic [AW-1:0] R_LAST   = AW'(IMG_H-K);
  localparam logic [AW-1:0] ONE      = AW'(1);

  typedef enum logic {U_IDLE, U_UNPK} u_state_t;
  typedef enum logic [1:0] {W_IDLE, W_RD, W_ADV} w_state_t;

  u_state_t      u_state, u_next;
  w_state_t      w_state, w_next;

  logic [7:0]    byte_q;
  logic [2:0]    bit_idx;
  logic [AW-1:0] wr_cnt;
  logic          wr_bit, wr_en, accept, ovf_hit, ovf_q;

  logic [AW-1:0] r, c, row_base, rd_row, ki, kj;
  logic [AW-1:0] rd_addr, br_addr;
  logic          frame_done_q, last_win, win_go;
  logic          rd_en, rd_first, rd_last;
  logic          pix_vld_q, pix_q, first_q, last_q;

  logic          mem [NPIX_I];

`ifdef CNN_WIN_MSB_FIRST_EN
  assign wr_bit = byte_q[3'd7 - bit_idx];
`else
  assign wr_bit = byte_q[bit_idx];
`endif

  // Unpacker state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             u_state <= U_IDLE;
    else if (bus.frame_clr) u_state <= U_IDLE;
    else                    u_state <= u_next;
  end

  // Unpacker next state: a byte is taken only when idle and the frame has room
  always_comb begin
    u_next = u_state;
    case (u_state)
      U_IDLE:  if (bus.rx_rdy && (wr_cnt < NPIX)) u_next = U_UNPK;
      U_UNPK:  if (bit_idx == 3'd7) u_next = U_IDLE;
      default: u_next = U_IDLE;
    endcase
  end

  // Unpacker outputs: strobe acceptance, RAM write enable, overflow hit
  always_comb begin
    accept  = (u_state == U_IDLE) && bus.rx_rdy && (wr_cnt < NPIX);
    wr_en   = (u_state == U_UNPK);
    ovf_hit = (u_state == U_UNPK) && bus.rx_rdy;
  end

  // Write-side datapath: byte latch, bit index, write count, sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q  <= '0;
      bit_idx <= '0;
      wr_cnt  <= '0;
      ovf_q   <= 1'b0;
    end else if (bus.frame_clr) begin
      byte_q  <= '0;
      bit_idx <= '0;
      wr_cnt  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        byte_q  <= bus.rx_data;
        bit_idx <= '0;
      end
      if (wr_en) begin
        wr_cnt  <= wr_cnt + ONE;
        bit_idx <= bit_idx + 3'd1;
      end
      if (ovf_hit) ovf_q <= 1'b1;
    end
  end

  // Image RAM write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt[IW-1:0]] <= wr_bit;
  end

  // Addresses built from running row bases; the bottom-right offset is constant
  assign br_addr  = row_base + c + BR_OFF;
  assign rd_addr  = rd_row + c + kj;
  assign last_win = (r == R_LAST) && (c == C_LAST);
  assign win_go   = !bus.core_bsy && !frame_done_q && (wr_cnt > br_addr);

  // Window state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             w_state <= W_IDLE;
    else if (bus.frame_clr) w_state <= W_IDLE;
    else                    w_state <= w_next;
  end

  // Window next state: core_bsy only gates the start of a window
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (win_go) w_next = W_RD;
      W_RD:    if ((ki == KM1) && (kj == KM1)) w_next = W_ADV;
      W_ADV:   w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Window outputs: read enable with first/last pixel tags
  always_comb begin
    rd_en    = (w_state == W_RD);
    rd_first = (w_state == W_RD) && (ki == '0) && (kj == '0);
    rd_last  = (w_state == W_RD) && (ki == KM1) && (kj == KM1);
  end

  // Window position and in-window read counters; the final window holds r/c
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0; c <= '0; row_base <= '0; rd_row <= '0; ki <= '0; kj <= '0;
      frame_done_q <= 1'b0;
    end else if (bus.frame_clr) begin
      r <= '0; c <= '0; row_base <= '0; rd_row <= '0; ki <= '0; kj <= '0;
      frame_done_q <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          rd_row <= row_base;
          ki     <= '0;
          kj     <= '0;
        end
        W_RD: begin
          if (kj == KM1) begin
            kj     <= '0;
            ki     <= ki + ONE;
            rd_row <= rd_row + ROW_STEP;
          end else begin
            kj <= kj + ONE;
          end
        end
        W_ADV: begin
          if (last_win) begin
            frame_done_q <= 1'b1;
          end else if (c == C_LAST) begin
            c        <= '0;
            r        <= r + ONE;
            row_base <= row_base + ROW_STEP;
          end else begin
            c <= c + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Synchronous RAM read and pixel output stage; a restart squashes reads in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_vld_q <= 1'b0; pix_q <= 1'b0; first_q <= 1'b0; last_q <= 1'b0;
    end else if (bus.frame_clr) begin
      pix_vld_q <= 1'b0; pix_q <= 1'b0; first_q <= 1'b0; last_q <= 1'b0;
    end else begin
      pix_vld_q <= rd_en;
      first_q   <= rd_first;
      last_q    <= rd_last;
      if (rd_en) pix_q <= mem[rd_addr[IW-1:0]];
    end
  end

  assign bus.pix_vld    = pix_vld_q;
  assign bus.pix        = pix_q;
  assign bus.win_first  = first_q;
  assign bus.win_last   = last_q;
  assign bus.frame_done = frame_done_q;
  assign bus.byte_ovf   = ovf_q;

endmodule
